// File: rtl/irq_capture_pkg.sv
// Shared definitions for the 4-channel interrupt capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irq_capture_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Saturating increment used by the per-channel event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val == max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/irq_chan.sv
// One capture channel: edge/level event detect, sticky pending flag, saturating counter.
// Latency: event at edge t is visible on pend/cnt after edge t (1 clk).
// Backpressure: none; every event is captured, counter saturates, ovf (IRQ_CAPTURE_OVF_EN) flags lost events.
module irq_chan
  import irq_capture_pkg::*;
#(
  parameter bit EDGE = 1'b1,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ev,
  input  logic          clr,
  output logic          evt,
  output logic          pend,
  output logic [CW-1:0] cnt
`ifdef IRQ_CAPTURE_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam logic [CW-1:0] CMAX = '1;

  logic ev_q;

  // Edge history; resets low so a line already high after reset counts once.
  always_ff @(posedge clk) begin
    if (rst) ev_q <= 1'b0;
    else     ev_q <= ev;
  end

  assign evt = EDGE ? (ev & ~ev_q) : ev;

  // Sticky pending flag; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)      pend <= 1'b0;
    else if (evt) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
  end

  // Saturating event counter; clear-then-count when clr and evt coincide.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= evt ? CW'(1) : '0;
    else if (evt) cnt <= CW'(sat_inc(32'(cnt), 32'(CMAX)));
  end

`ifdef IRQ_CAPTURE_OVF_EN
  // Lost-event flag: an event arrived while the previous one was still pending.
  always_ff @(posedge clk) begin
    if (rst)              ovf <= 1'b0;
    else if (evt && pend) ovf <= 1'b1;
    else if (clr)         ovf <= 1'b0;
  end
`endif

endmodule

// File: rtl/irq_capture4.sv
// 4-channel sticky event capture with counters and one acknowledged irq (optional ovf via IRQ_CAPTURE_OVF_EN).
// Latency: pend 1 clk after event edge, irq 1 clk after a masked-in pend; cnt_out combinational from regs.
// Backpressure: none; irq stays high until ack or until no masked-in flag remains pending.
module irq_capture4
  import irq_capture_pkg::*;
#(
  parameter bit EDGE = 1'b1,
  parameter int CW   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ev,
  input  logic [NCH-1:0] mask,
  input  logic [NCH-1:0] clr,
  input  logic           ack,
  input  logic [1:0]     cnt_sel,
  output logic [NCH-1:0] pend,
  output logic           irq,
  output logic [CW-1:0]  cnt_out
`ifdef IRQ_CAPTURE_OVF_EN
  ,
  output logic [NCH-1:0] ovf
`endif
);

  logic [NCH-1:0] evt;
  logic [CW-1:0]  cnt [NCH];
  logic           any;
  logic           new_evt;
  irq_state_t     state, state_nxt;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    irq_chan #(
      .EDGE (EDGE),
      .CW   (CW)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .ev   (ev[i]),
      .clr  (clr[i]),
      .evt  (evt[i]),
      .pend (pend[i]),
      .cnt  (cnt[i])
`ifdef IRQ_CAPTURE_OVF_EN
      ,
      .ovf  (ovf[i])
`endif
    );
  end

  assign any     = |(pend & mask);
  assign new_evt = |(evt & mask);
  assign cnt_out = cnt[cnt_sel];

  // State register plus registered irq decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      irq   <= (state_nxt == ASSERT);
    end
  end

  // Next-state: raise on pending, drop to SERVICE on ack, re-raise on fresh masked-in events.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any) state_nxt = ASSERT;
      end
      ASSERT: begin
        if (!any)     state_nxt = IDLE;
        else if (ack) state_nxt = SERVICE;
      end
      SERVICE: begin
        if (new_evt)   state_nxt = ASSERT;
        else if (!any) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_capture4.sv
// Randomized and directed bench for irq_capture4 against a behavioural reference model.
// Latency: model advances once per rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: n/a.
module tb_irq_capture4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ev = 4'hF, mask = 4'h0, clr = 4'h0;
  logic       ack = 1'b0;
  logic [1:0] cnt_sel = 2'd0;
  logic [3:0] pend;
  logic       irq;
  logic [3:0] cnt_out;
`ifdef IRQ_CAPTURE_OVF_EN
  logic [3:0] ovf;
`endif

  irq_capture4 #(.EDGE(1'b1), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ev      (ev),
    .mask    (mask),
    .clr     (clr),
    .ack     (ack),
    .cnt_sel (cnt_sel),
    .pend    (pend),
    .irq     (irq),
    .cnt_out (cnt_out)
`ifdef IRQ_CAPTURE_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-channel counts as integers, irq phase as 0=quiet, 1=raised, 2=acknowledged.
  logic [3:0] m_pend = 4'h0, m_prev = 4'h0, m_ovf = 4'h0;
  int         m_cnt [4] = '{0, 0, 0, 0};
  int         m_phase = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] fresh;
    bit         pending_in, fresh_in;
    if (rst) begin
      m_pend = 0; m_prev = 0; m_ovf = 0; m_phase = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      return;
    end
    fresh      = ev & ~m_prev;
    pending_in = (m_pend & mask) != 0;
    fresh_in   = (fresh & mask) != 0;
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) m_cnt[i] = 0;
      if (fresh[i]) m_cnt[i] = (m_cnt[i] >= 15) ? 15 : m_cnt[i] + 1;
      if (fresh[i] && m_pend[i]) m_ovf[i] = 1'b1;
      else if (clr[i]) m_ovf[i] = 1'b0;
      if (fresh[i]) m_pend[i] = 1'b1;
      else if (clr[i]) m_pend[i] = 1'b0;
    end
    m_prev = ev;
    if (m_phase == 0) begin
      if (pending_in) m_phase = 1;
    end else if (m_phase == 1) begin
      if (!pending_in) m_phase = 0;
      else if (ack)    m_phase = 2;
    end else begin
      if (fresh_in)        m_phase = 1;
      else if (!pending_in) m_phase = 0;
    end
  endtask

  task automatic step(input logic [3:0] e, input logic [3:0] m, input logic [3:0] c,
                      input logic a, input logic [1:0] s, input logic r);
    ev = e; mask = m; clr = c; ack = a; cnt_sel = s; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("pend", 32'(pend), 32'(m_pend));
    chk("irq", 32'(irq), 32'(m_phase == 1));
    chk("cnt_out", 32'(cnt_out), 32'(m_cnt[s]));
`ifdef IRQ_CAPTURE_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
  endtask

  initial begin
    // Reset with all lines high, walking the counter select.
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 4'h0, 4'h0, 1'b0, 2'(k), 1'b1);
      chk("rst_pend", 32'(pend), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_cnt", 32'(cnt_out), 32'h0);
    end
    step(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);

    // Held-high line on channel 0 with mask 1.
    step(4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("d2_pend", 32'(pend), 32'h1);
    chk("d2_irq_early", 32'(irq), 32'h0);
    step(4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("d2_irq", 32'(irq), 32'h1);
    for (int k = 0; k < 3; k++) step(4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("d2_cnt0", 32'(cnt_out), 32'h1);

    // Ack, clear, then a fresh pulse raises irq again.
    step(4'h0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0);
    chk("d3_ack", 32'(irq), 32'h0);
    step(4'h0, 4'h1, 4'h1, 1'b0, 2'd0, 1'b0);
    chk("d3_clr", 32'(pend), 32'h0);
    step(4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    step(4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    step(4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("d3_reraise", 32'(irq), 32'h1);

    // Event and clear on the same cycle: set wins, count restarts at 1.
    step(4'h4, 4'h1, 4'h4, 1'b0, 2'd2, 1'b0);
    chk("d4_pend2", 32'(pend[2]), 32'h1);
    chk("d4_cnt2", 32'(cnt_out), 32'h1);
    step(4'h0, 4'h1, 4'h0, 1'b0, 2'd2, 1'b0);
    step(4'h4, 4'h1, 4'h0, 1'b0, 2'd2, 1'b0);
`ifdef IRQ_CAPTURE_OVF_EN
    chk("d4_ovf2", 32'(ovf[2]), 32'h1);
`endif

    // Saturation on channel 3, then clear.
    for (int k = 0; k < 20; k++) begin
      step(4'h8, 4'h1, 4'h0, 1'b0, 2'd3, 1'b0);
      step(4'h0, 4'h1, 4'h0, 1'b0, 2'd3, 1'b0);
    end
    chk("d5_sat", 32'(cnt_out), 32'hF);
    step(4'h0, 4'h1, 4'h8, 1'b0, 2'd3, 1'b0);
    chk("d5_clr", 32'(cnt_out), 32'h0);

    // Masked pending, unmask raises irq, reset mid-assert drops it.
    step(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1);
    step(4'h2, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0);
    chk("d6_pend", 32'(pend), 32'h2);
    step(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0);
    chk("d6_masked_irq", 32'(irq), 32'h0);
    step(4'h0, 4'h2, 4'h0, 1'b0, 2'd1, 1'b0);
    chk("d6_unmask_irq", 32'(irq), 32'h1);
    step(4'h0, 4'h2, 4'h0, 1'b0, 2'd1, 1'b1);
    chk("d6_rst_irq", 32'(irq), 32'h0);
    step(4'h0, 4'h2, 4'h0, 1'b0, 2'd1, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(4'($urandom),
           4'($urandom),
           ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'h0,
           1'($urandom_range(0, 3) == 0),
           2'($urandom),
           1'($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
